// File: rtl/flash_read_sequencer_if.sv
// Signal bundle between the flash read sequencer, the SPI reader it drives and
// the downstream word consumer.
interface flash_read_sequencer_if;
   logic        start;
   logic [23:0] start_addr;
   logic [15:0] word_count;
   logic        busy;
   logic        done;
   logic        addr_buffer_free;
   logic        addr_en;
   logic [23:0] addr_data;
   logic        rd_data_available;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   // slave: the sequencer itself; master: the surrounding system
   modport slave (
      input  start, start_addr, word_count, addr_buffer_free,
             rd_data_available, rd_data, out_ready,
      output busy, done, addr_en, addr_data, rd_ack, out_valid, out_data
   );

   modport master (
      output start, start_addr, word_count, addr_buffer_free,
             rd_data_available, rd_data, out_ready,
      input  busy, done, addr_en, addr_data, rd_ack, out_valid, out_data
   );
endinterface

// File: rtl/flash_read_sequencer.sv
// Burst reader: issues consecutive flash word addresses to an SPI reader and
// buffers the returned words in a small FIFO for a downstream consumer.
module flash_read_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_STEP  = 4
) (
   input logic                   clk,
   input logic                   reset,
   flash_read_sequencer_if.slave bus
);
   // state       | meaning
   // S_IDLE      | waiting for start
   // S_ISSUE     | waiting for addr_buffer_free to strobe the next address
   // S_WAIT_DATA | waiting for a read word and FIFO room, then ack it
   // S_ACK_WAIT  | waiting for rd_data_available to drop after the ack
   // S_DONE      | burst finished; done pulses on the following cycle
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_DATA, S_ACK_WAIT, S_DONE
   } state_t;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   state_t           state_q;
   logic [23:0]      cur_addr_q;
   logic [23:0]      addr_data_q;
   logic [15:0]      remaining_q;
   logic             busy_q;
   logic             done_q;
   logic             addr_en_q;

   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic             pop;
   logic             push_ok;
   logic             push;

   assign pop     = (count_q != '0) && bus.out_ready;
   assign push_ok = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
   // The ack is combinational so it can only ever coincide with valid read data.
   assign push    = (state_q == S_WAIT_DATA) && bus.rd_data_available && push_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         addr_data_q <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         addr_en_q   <= 1'b0;
      end else begin
         addr_en_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  cur_addr_q  <= bus.start_addr;
                  remaining_q <= bus.word_count;
                  busy_q      <= 1'b1;
                  state_q     <= (bus.word_count != '0) ? S_ISSUE : S_DONE;
               end
            end
            S_ISSUE: begin
               if (bus.addr_buffer_free) begin
                  addr_en_q   <= 1'b1;
                  addr_data_q <= cur_addr_q;
                  state_q     <= S_WAIT_DATA;
               end
            end
            S_WAIT_DATA: begin
               if (push) begin
                  cur_addr_q  <= cur_addr_q + 24'(ADDR_STEP);
                  remaining_q <= remaining_q - 16'd1;
                  state_q     <= S_ACK_WAIT;
               end
            end
            S_ACK_WAIT: begin
               if (!bus.rd_data_available) begin
                  state_q <= (remaining_q == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
   end

   // Storage needs no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.rd_data;
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.addr_en   = addr_en_q;
   assign bus.addr_data = addr_data_q;
   assign bus.rd_ack    = push;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = mem_q[rd_ptr_q];
endmodule
